// File: rtl/down_counter.sv
// Loadable down counter with zero flag and a one-cycle done pulse on the 1 -> 0 step.
// Optional auto-reload is enabled by defining DOWN_COUNTER_RELOAD_EN. With it, an
// enabled step at zero reloads the last loaded value and pulses wrap. Without it, the
// counter holds at zero and wrap is tied low.
module down_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             done,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;

`ifdef DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             wrap_q, wrap_d;

    // Next state: load wins, then decrement, then reload at zero; pulses default low.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
        end else if (enable) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
                done_d  = (count_q == WIDTH'(1));
            end else begin
                count_d = reload_q;
                wrap_d  = 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`else
    // Next state: load wins, then decrement; at zero the count simply holds.
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
            done_d  = (count_q == WIDTH'(1));
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign wrap = 1'b0;
`endif

    assign count = count_q;
    assign done  = done_q;
    // Derived from the register so it tracks count through reset too.
    assign zero  = (count_q == '0);

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter (WIDTH=3). The stimulus process drives inputs on
// the falling edge and queues the expected post-edge outputs from a behavioural model.
// The monitor samples 1ns after each rising edge and compares against the queue.
// The model follows DOWN_COUNTER_RELOAD_EN the same way the design does.
module tb_down_counter;

    localparam int unsigned WIDTH = 3;
    localparam int          MAXV  = (1 << WIDTH) - 1;

    logic             clock;
    logic             reset_n;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             done;
    logic             wrap;

    typedef struct {
        int cnt;
        bit dn;
        bit wr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model state, kept as plain integers.
    int m_cnt    = 0;
    int m_reload = 0;

    down_counter #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .count      (count),
        .zero       (zero),
        .done       (done),
        .wrap       (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model computes what the next rising edge must produce.
    task automatic step(input bit ld, input int lv, input bit en);
        exp_t e;
        @(negedge clock);
        reset_n    = 1'b1;
        load       = ld;
        load_value = WIDTH'(lv);
        enable     = en;
        e.dn = 1'b0;
        e.wr = 1'b0;
        if (ld) begin
            m_cnt    = lv;
            m_reload = lv;
        end else if (en) begin
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                e.dn  = (m_cnt == 0);
            end else begin
`ifdef DOWN_COUNTER_RELOAD_EN
                m_cnt = m_reload;
                e.wr  = 1'b1;
`endif
            end
        end
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // Assert reset between edges and check the outputs clear without a clock.
    task automatic async_reset();
        exp_t e;
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        load    = 1'b0;
        enable  = 1'b0;
        #1;
        check("reset_count", int'(count), 0);
        check("reset_zero", int'(zero), 1);
        check("reset_done", int'(done), 0);
        check("reset_wrap", int'(wrap), 0);
        m_cnt    = 0;
        m_reload = 0;
        e.cnt = 0;
        e.dn  = 1'b0;
        e.wr  = 1'b0;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge once stimulus is running.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            check("zero_vs_count", int'(zero), int'(count == '0));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count", int'(count), e.cnt);
                check("done", int'(done), int'(e.dn));
                check("wrap", int'(wrap), int'(e.wr));
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        load       = 1'b0;
        load_value = '0;
        enable     = 1'b0;
        #1;
        check("por_count", int'(count), 0);
        check("por_zero", int'(zero), 1);
        repeat (2) @(negedge clock);

        // Reset mid-count from 4.
        step(1, 4, 0);
        step(0, 0, 0);
        async_reset();

        // Basic count from 5 to 0, then a few enables at zero.
        step(1, 5, 0);
        repeat (5) step(0, 0, 1);
        repeat (3) step(0, 0, 1);

        // Reload behaviour (holds at zero in the default build).
        step(1, 2, 0);
        repeat (4) step(0, 0, 1);

        // Load priority over enable.
        step(1, 3, 0);
        step(1, 6, 1);
        step(0, 0, 0);

        // Load to zero, then 1 and a single enable.
        step(1, 0, 0);
        step(0, 0, 1);
        step(1, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);

        // Reload register is zero again after reset.
        async_reset();
        repeat (3) step(0, 0, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 7) == 0, int'($urandom_range(0, MAXV)),
                     $urandom_range(0, 3) != 0);
            end
        end

        step(0, 0, 0);
        repeat (2) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL provide parameter: WIDTH, default 3, counter width in bits (legal 1..16).
REQ-002 SHALL provide port: clock  input  1  single clock for all state, rising-edge.
REQ-003 SHALL provide port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: load  input  1  synchronous load strobe.
REQ-005 SHALL provide port: load_value  input  WIDTH  value captured on load.
REQ-006 SHALL provide port: enable  input  1  decrement request, one step per rising edge.
REQ-007 SHALL provide port: count  output  WIDTH  current counter value, registered.
REQ-008 SHALL provide port: zero  output  1  high whenever count == 0, combinational from count.
REQ-009 SHALL provide port: done  output  1  registered one-cycle pulse marking a decrement from 1 to 0.
REQ-010 SHALL provide port: wrap  output  1  registered one-cycle pulse marking an auto-reload; tied 0 without DOWN_COUNTER_RELOAD_EN.

Function
REQ-011 SHALL update all state only on the rising edge of clock, except for reset.
REQ-012 SHALL give load priority over enable: when load=1, count <= load_value, done <= 0 and wrap <= 0, regardless of enable.
REQ-013 SHALL, when load=0, enable=1 and count > 0, set count <= count - 1 with no other side effects.
REQ-014 SHALL, on the edge where count goes 1 -> 0 by decrement, set done = 1 for exactly that following cycle; done = 0 in all other cycles.
REQ-015 SHALL NOT assert done when 0 is reached by load or reset.
REQ-016 SHALL, when load=0 and enable=0, hold count; done and wrap return to 0.
REQ-017 SHALL, with enable=1 at count == 0, behave per REQ-022/REQ-023; count SHALL never wrap to all-ones.
REQ-018 SHALL keep zero consistent with count in every cycle, including during and directly after reset.
REQ-019 SHALL keep all outputs free of X after reset for any legal input sequence.

Reset
REQ-020 SHALL, while reset_n=0, immediately and without a clock edge force count=0, done=0, wrap=0 and reload register=0; zero therefore reads 1.
REQ-021 SHALL, on reset_n assertion mid-count, abandon the count with no done or wrap pulse; the first edge after release acts on the inputs normally.

Configuration
REQ-022 SHALL, with DOWN_COUNTER_RELOAD_EN defined, hold a WIDTH-bit reload register captured from load_value on every load; at count==0 with enable=1 and load=0, count <= reload register and wrap = 1 for the next cycle. With reload register 0, count stays 0 and wrap pulses on every enabled cycle.
REQ-023 SHALL, without DOWN_COUNTER_RELOAD_EN, omit the reload register, hold count at 0 when enable=1 at count==0, and drive wrap constantly 0; the port list is unchanged.

Verification (WIDTH=3)
REQ-024 SHALL cover reset: reset_n=0 asynchronously with count=4 -> count=0, zero=1, done=0, wrap=0 before the next edge.
REQ-025 SHALL cover basic count: load=1, load_value=5, then enable=1 for 5 cycles -> count 4,3,2,1,0; done=1 only in the cycle count first reads 0; zero=1 from then on.
REQ-026 SHALL cover the no-reload build: from count=0, enable=1 for 3 cycles -> count stays 0, done=0, wrap=0.
REQ-027 SHALL cover the reload build: load_value=2 loaded, enable=1 for 4 cycles -> count 1,0,2,1; done pulses at 0; wrap pulses in the cycle count reads 2.
REQ-028 SHALL cover load priority: count=3, load=1 and enable=1 together with load_value=6 -> count=6, done=0.
REQ-029 SHALL cover the load-to-zero boundary: load=1, load_value=0 -> count=0, zero=1, done=0; then load_value=1 and one enable -> done=1.
